// File: rtl/div_pkg.sv
// Shared definitions for the divider family: operand width and the
// IDLE/CALC/DONE sequencing states used by the sequential arithmetic blocks.
package div_pkg;

    localparam int DIV_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Step counter width: clog2 of the step count, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/divider_4bit_recon.sv
// Dividend reconstruction: dividend = quotient * divisor + remainder, computed
// with a W-step shift-add multiplier seeded with the remainder. Flags results
// wider than W bits and remainders that are not smaller than the divisor.
//
// state | meaning
// IDLE  | waiting for operands; in_ready high once out of reset
// CALC  | one shift-add step per edge, W steps in total
// DONE  | result presented, held until out_ready
module divider_4bit_recon
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   quotient,
    input  logic [W-1:0]   divisor,
    input  logic [W-1:0]   remainder,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] dividend,
    output logic           fits,
    output logic           rem_err
);

    localparam int CW = cnt_width(W);
    localparam int RW = 2 * W;

    div_state_e    state_q,     state_d;
    logic [RW-1:0] acc_q,       acc_d;
    logic [RW-1:0] mcand_q,     mcand_d;
    logic [W-1:0]  mplier_q,    mplier_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          rem_chk_q,   rem_chk_d;
    logic [RW-1:0] dividend_q,  dividend_d;
    logic          fits_q,      fits_d;
    logic          rem_err_q,   rem_err_d;
    // Holds in_ready low until the first edge after reset is released.
    logic          started_q,   started_d;
    logic [RW-1:0] acc_sum;

    // Next-state and datapath step computation.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        rem_chk_d  = rem_chk_q;
        dividend_d = dividend_q;
        fits_d     = fits_q;
        rem_err_d  = rem_err_q;
        started_d  = 1'b1;
        acc_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        case (state_q)
            IDLE: begin
                if (in_valid && started_q) begin
                    mcand_d   = {{W{1'b0}}, divisor};
                    mplier_d  = quotient;
                    acc_d     = {{W{1'b0}}, remainder};
                    rem_chk_d = (remainder >= divisor);
                    cnt_d     = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // No early exit on a zero multiplier: latency is always W.
                if (cnt_q == CW'(W - 1)) begin
                    state_d    = DONE;
                    dividend_d = acc_sum;
                    fits_d     = (acc_sum[RW-1:W] == '0);
                    rem_err_d  = rem_chk_q;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            rem_chk_q  <= 1'b0;
            dividend_q <= '0;
            fits_q     <= 1'b0;
            rem_err_q  <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            rem_chk_q  <= rem_chk_d;
            dividend_q <= dividend_d;
            fits_q     <= fits_d;
            rem_err_q  <= rem_err_d;
            started_q  <= started_d;
        end
    end

    assign in_ready  = started_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign dividend  = dividend_q;
    assign fits      = fits_q;
    assign rem_err   = rem_err_q;

endmodule
